// File: rtl/spi_slave_engine.sv
// Responder-side SPI engine: oversamples external SCK/SS_n/MOSI in the pclk domain and
// shifts 1-32 bit words in any CPOL/CPHA mode, popping TX words and pushing RX words.
module spi_slave_engine #(
    parameter int DATA_MAX = 32
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                spie,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                dord,
    input  logic [4:0]          datalen,
    input  logic                sck_in,
    input  logic                ss_n_in,
    input  logic                mosi_in,
    output logic                miso_out,
    output logic                miso_oe,
    input  logic [DATA_MAX-1:0] tfifo_rdata,
    input  logic                tfifo_empty,
    output logic                tfifo_ren,
    output logic [DATA_MAX-1:0] rfifo_wdata,
    input  logic                rfifo_full,
    output logic                rfifo_wen,
    output logic                transfer_complete,
    output logic                busy,
    output logic                tx_underrun,
    output logic                rx_overrun,
    output logic                ss_abort
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_COMMIT} state_t;

    state_t              state_reg;
    logic [2:0]          pin_meta_reg;
    logic [2:0]          pin_sync_reg;
    logic                sck_prev_reg;
    logic                ss_act_prev_reg;
    logic                cpol_reg;
    logic                cpha_reg;
    logic                dord_reg;
    logic [4:0]          len_reg;
    logic [DATA_MAX-1:0] tx_sh_reg;
    logic [DATA_MAX-1:0] rx_sh_reg;
    logic [5:0]          bit_cnt_reg;
    logic                have_tx_reg;

    logic                sck_s;
    logic                ss_act;
    logic                mosi_s;
    logic                sck_rise;
    logic                sck_fall;
    logic                lead_edge;
    logic                trail_edge;
    logic                sample_edge;
    logic                drive_edge;
    logic [4:0]          rx_idx;
    logic [DATA_MAX-1:0] rx_next;
    logic [DATA_MAX-1:0] tx_next;
    logic                tx_bit;
    logic                last_sample;

    // Pad synchronizers carry no reset: they only ever mirror the pins.
    always_ff @(posedge pclk) begin
        pin_meta_reg <= {mosi_in, ss_n_in, sck_in};
        pin_sync_reg <= pin_meta_reg;
        sck_prev_reg <= pin_sync_reg[0];
    end

    // Reset to "selected" so a master already mid-frame cannot start a bogus word.
    always_ff @(posedge pclk) begin
        if (preset) ss_act_prev_reg <= 1'b1;
        else        ss_act_prev_reg <= ss_act;
    end

    assign sck_s       = pin_sync_reg[0];
    assign ss_act      = ~pin_sync_reg[1];
    assign mosi_s      = pin_sync_reg[2];
    assign sck_rise    = sck_s & ~sck_prev_reg;
    assign sck_fall    = ~sck_s & sck_prev_reg;
    assign lead_edge   = cpol_reg ? sck_fall : sck_rise;
    assign trail_edge  = cpol_reg ? sck_rise : sck_fall;
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign drive_edge  = cpha_reg ? lead_edge : trail_edge;
    assign last_sample = (bit_cnt_reg == {1'b0, len_reg});

    assign rx_idx  = dord_reg ? bit_cnt_reg[4:0] : (len_reg - bit_cnt_reg[4:0]);
    assign tx_next = dord_reg ? {1'b0, tx_sh_reg[DATA_MAX-1:1]} : {tx_sh_reg[DATA_MAX-2:0], 1'b0};
    assign tx_bit  = dord_reg ? tx_sh_reg[0] : tx_sh_reg[len_reg];
    assign busy    = (state_reg != ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_MAX; gi++) begin : g_rx
            assign rx_next[gi] = (rx_idx == 5'(gi)) ? mosi_s : rx_sh_reg[gi];
        end
    endgenerate

    always_ff @(posedge pclk) begin
        tfifo_ren         <= 1'b0;
        rfifo_wen         <= 1'b0;
        transfer_complete <= 1'b0;
        tx_underrun       <= 1'b0;
        rx_overrun        <= 1'b0;
        ss_abort          <= 1'b0;
        if (preset || !spie) begin
            state_reg   <= ST_IDLE;
            miso_out    <= 1'b0;
            miso_oe     <= 1'b0;
            rfifo_wdata <= '0;
            tx_sh_reg   <= '0;
            rx_sh_reg   <= '0;
            bit_cnt_reg <= '0;
            have_tx_reg <= 1'b0;
            cpol_reg    <= 1'b0;
            cpha_reg    <= 1'b0;
            dord_reg    <= 1'b0;
            len_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    miso_out <= 1'b0;
                    miso_oe  <= 1'b0;
                    if (ss_act && !ss_act_prev_reg) begin
                        state_reg   <= ST_LOAD;
                        tfifo_ren   <= !tfifo_empty;
                        tx_underrun <= tfifo_empty;
                        have_tx_reg <= !tfifo_empty;
                    end
                end
                ST_LOAD: begin
                    if (!ss_act) begin
                        state_reg <= ST_IDLE;
                        ss_abort  <= 1'b1;
                        miso_out  <= 1'b0;
                        miso_oe   <= 1'b0;
                    end else begin
                        cpol_reg    <= cpol;
                        cpha_reg    <= cpha;
                        dord_reg    <= dord;
                        len_reg     <= datalen;
                        tx_sh_reg   <= have_tx_reg ? tfifo_rdata : '0;
                        miso_out    <= have_tx_reg & (dord ? tfifo_rdata[0] : tfifo_rdata[datalen]);
                        miso_oe     <= 1'b1;
                        bit_cnt_reg <= '0;
                        rx_sh_reg   <= '0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A deassert landing with an SCK edge wins over the edge.
                    if (!ss_act) begin
                        state_reg <= ST_IDLE;
                        ss_abort  <= 1'b1;
                        miso_out  <= 1'b0;
                        miso_oe   <= 1'b0;
                    end else begin
                        miso_out <= tx_bit;
                        if (sample_edge) begin
                            rx_sh_reg   <= rx_next;
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            if (last_sample) begin
                                state_reg         <= ST_COMMIT;
                                rfifo_wdata       <= rx_next;
                                transfer_complete <= 1'b1;
                                rfifo_wen         <= !rfifo_full;
                                rx_overrun        <= rfifo_full;
                            end
                        end else if (drive_edge && bit_cnt_reg != 6'd0) begin
                            tx_sh_reg <= tx_next;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (ss_act) begin
                        state_reg   <= ST_LOAD;
                        tfifo_ren   <= !tfifo_empty;
                        tx_underrun <= tfifo_empty;
                        have_tx_reg <= !tfifo_empty;
                    end else begin
                        state_reg <= ST_IDLE;
                        miso_out  <= 1'b0;
                        miso_oe   <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_engine.sv
// Bench for spi_slave_engine: behavioural SPI master, TX FIFO model and RX/MISO scoreboards.
module tb_spi_slave_engine;
    localparam int H = 8;  // SCK half-period in pclk cycles

    logic        pclk = 1'b0;
    logic        preset, spie, cpol, cpha, dord;
    logic [4:0]  datalen;
    logic        sck_in, ss_n_in, mosi_in;
    logic        miso_out, miso_oe;
    logic [31:0] tfifo_rdata = 32'h0;
    logic        tfifo_empty = 1'b1;
    logic        tfifo_ren;
    logic [31:0] rfifo_wdata;
    logic        rfifo_full, rfifo_wen;
    logic        transfer_complete, busy, tx_underrun, rx_overrun, ss_abort;

    int n_checks = 0;
    int n_fail = 0;
    int n_ren = 0, n_wen = 0, n_tc = 0, n_under = 0, n_over = 0, n_abort = 0;
    logic [31:0] txq[$];
    logic [31:0] exp_rx[$];
    logic        exp_miso[$];
    logic [5:0]  prev_ev = 6'b0;

    always #5 pclk = ~pclk;

    spi_slave_engine #(.DATA_MAX(32)) dut (
        .pclk(pclk), .preset(preset), .spie(spie), .cpol(cpol), .cpha(cpha), .dord(dord),
        .datalen(datalen), .sck_in(sck_in), .ss_n_in(ss_n_in), .mosi_in(mosi_in),
        .miso_out(miso_out), .miso_oe(miso_oe), .tfifo_rdata(tfifo_rdata),
        .tfifo_empty(tfifo_empty), .tfifo_ren(tfifo_ren), .rfifo_wdata(rfifo_wdata),
        .rfifo_full(rfifo_full), .rfifo_wen(rfifo_wen), .transfer_complete(transfer_complete),
        .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .ss_abort(ss_abort)
    );

    // First-word-fall-through TX FIFO
    always @(posedge pclk) begin
        if (tfifo_ren === 1'b1 && txq.size() > 0) void'(txq.pop_front());
        tfifo_empty <= (txq.size() == 0);
        tfifo_rdata <= (txq.size() > 0) ? txq[0] : 32'h0;
    end

    // Output monitor: RX scoreboard, event counters, pulse-width checks
    always @(negedge pclk) begin
        logic [5:0] ev;
        logic [31:0] exp_w;
        ev = {tfifo_ren, rfifo_wen, transfer_complete, tx_underrun, rx_overrun, ss_abort};
        if (tfifo_ren) n_ren++;
        if (transfer_complete) n_tc++;
        if (rx_overrun) n_over++;
        if (ss_abort) n_abort++;
        if (tfifo_ren || tx_underrun) begin
            if (tx_underrun) n_under++;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_busy: busy=%b during TX pop/underrun, expected 1", busy);
            end
        end
        if (rfifo_wen) begin
            n_wen++;
            n_checks++;
            if (exp_rx.size() == 0) begin
                n_fail++;
                $display("FAIL rx_push_unexpected: got %h, expected no push", rfifo_wdata);
            end else begin
                exp_w = exp_rx.pop_front();
                if (rfifo_wdata !== exp_w) begin
                    n_fail++;
                    $display("FAIL rx_word: got %h expected %h", rfifo_wdata, exp_w);
                end
            end
        end
        if (ev != 6'b0) begin
            n_checks++;
            if ((ev & prev_ev) != 6'b0) begin
                n_fail++;
                $display("FAIL pulse_width: events %b held from %b, expected single-cycle", ev, prev_ev);
            end
        end
        prev_ev = ev;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_mode(input logic p, input logic ph, input logic d, input logic [4:0] len);
        cpol = p; cpha = ph; dord = d; datalen = len; sck_in = p;
        clk_wait(4);
    endtask

    task automatic push_miso(input logic [31:0] w, input int nbits, input int nsamp);
        for (int i = 0; i < nsamp; i++) exp_miso.push_back(dord ? w[i] : w[nbits-1-i]);
    endtask

    task automatic push_tx(input logic [31:0] w, input int nbits, input int nsamp);
        txq.push_back(w);
        push_miso(w, nbits, nsamp);
    endtask

    task automatic ss_assert();
        ss_n_in = 1'b0;
        clk_wait(H);
    endtask

    task automatic ss_release();
        ss_n_in = 1'b1;
        clk_wait(2 * H);
    endtask

    // Master: nsamp bits of mw; when rel is set, SS_n rises one pclk after the final sample edge.
    task automatic spi_word(input logic [31:0] mw, input int nbits, input int nsamp, input logic rel);
        logic b, e;
        for (int i = 0; i < nsamp; i++) begin
            b = dord ? mw[i] : mw[nbits-1-i];
            if (cpha) sck_in = ~sck_in;
            mosi_in = b;
            clk_wait(H);
            n_checks++;
            if (exp_miso.size() == 0) begin
                n_fail++;
                $display("FAIL miso_bit: no expected bit queued for sample %0d", i);
            end else begin
                e = exp_miso.pop_front();
                if (miso_out !== e || miso_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL miso_bit %0d: got miso=%b oe=%b expected miso=%b oe=1", i, miso_out, miso_oe, e);
                end
            end
            sck_in = ~sck_in;
            if (rel && i == nbits - 1) begin
                clk_wait(1);
                ss_n_in = 1'b1;
                clk_wait(H - 1);
            end else begin
                clk_wait(H);
            end
            if (!cpha) sck_in = ~sck_in;
        end
        if (rel) clk_wait(2 * H);
    endtask

    task automatic test_reset();
        preset = 1'b1; spie = 1'b1; rfifo_full = 1'b0;
        cpol = 1'b0; cpha = 1'b0; dord = 1'b0; datalen = 5'd7;
        sck_in = 1'b0; ss_n_in = 1'b1; mosi_in = 1'b0;
        clk_wait(5);
        n_checks++;
        if ({miso_out, miso_oe, tfifo_ren, rfifo_wen, transfer_complete, busy, tx_underrun,
             rx_overrun, ss_abort} !== 9'b0 || rfifo_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flags %b data %h expected all 0",
                     {miso_out, miso_oe, tfifo_ren, rfifo_wen, transfer_complete, busy,
                      tx_underrun, rx_overrun, ss_abort}, rfifo_wdata);
        end
        preset = 1'b0;
        clk_wait(6);
        n_checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b oe=%b expected 0 0", busy, miso_oe);
        end
    endtask

    task automatic test_mode0_basic();
        int r0 = n_ren, w0 = n_wen, t0 = n_tc, u0 = n_under, a0 = n_abort;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        push_tx(32'hA5, 8, 8);
        exp_rx.push_back(32'h0000003C);
        ss_assert();
        spi_word(32'h3C, 8, 8, 1'b1);
        n_checks++;
        if (n_ren - r0 != 1 || n_wen - w0 != 1 || n_tc - t0 != 1) begin
            n_fail++;
            $display("FAIL mode0_counts: got ren=%0d wen=%0d tc=%0d expected 1 1 1", n_ren - r0, n_wen - w0, n_tc - t0);
        end
        n_checks++;
        if (n_under - u0 != 0 || n_abort - a0 != 0) begin
            n_fail++;
            $display("FAIL mode0_events: got underrun=%0d abort=%0d expected 0 0", n_under - u0, n_abort - a0);
        end
    endtask

    task automatic test_back_to_back();
        int r0 = n_ren, w0 = n_wen, t0 = n_tc;
        set_mode(1'b1, 1'b1, 1'b1, 5'd15);
        push_tx(32'h1234, 16, 16);
        push_tx(32'hBEEF, 16, 16);
        exp_rx.push_back(32'h000000FF);
        exp_rx.push_back(32'h00008001);
        ss_assert();
        spi_word(32'h00FF, 16, 16, 1'b0);
        spi_word(32'h8001, 16, 16, 1'b1);
        n_checks++;
        if (n_ren - r0 != 2 || n_wen - w0 != 2 || n_tc - t0 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got ren=%0d wen=%0d tc=%0d expected 2 2 2", n_ren - r0, n_wen - w0, n_tc - t0);
        end
    endtask

    task automatic test_underrun();
        int r0 = n_ren, w0 = n_wen, u0 = n_under;
        set_mode(1'b0, 1'b1, 1'b0, 5'd7);
        push_miso(32'h0, 8, 8);
        exp_rx.push_back(32'h0000005A);
        ss_assert();
        spi_word(32'h5A, 8, 8, 1'b1);
        n_checks++;
        if (n_under - u0 != 1 || n_ren - r0 != 0 || n_wen - w0 != 1) begin
            n_fail++;
            $display("FAIL underrun_counts: got underrun=%0d ren=%0d wen=%0d expected 1 0 1", n_under - u0, n_ren - r0, n_wen - w0);
        end
    endtask

    task automatic test_overrun();
        int w0 = n_wen, t0 = n_tc, o0 = n_over;
        set_mode(1'b0, 1'b0, 1'b0, 5'd31);
        rfifo_full = 1'b1;
        push_tx(32'hC001D00D, 32, 32);
        ss_assert();
        spi_word(32'hDEADBEEF, 32, 32, 1'b1);
        rfifo_full = 1'b0;
        n_checks++;
        if (n_over - o0 != 1 || n_wen - w0 != 0 || n_tc - t0 != 1) begin
            n_fail++;
            $display("FAIL overrun_counts: got overrun=%0d wen=%0d tc=%0d expected 1 0 1", n_over - o0, n_wen - w0, n_tc - t0);
        end
    endtask

    task automatic test_abort();
        int w0 = n_wen, t0 = n_tc, a0 = n_abort;
        logic found = 1'b0;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        push_tx(32'h3C, 8, 3);
        ss_assert();
        spi_word(32'h99, 8, 3, 1'b0);
        ss_n_in = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge pclk);
            if (ss_abort) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_pulse: ss_abort not seen within 20 cycles, expected 1 pulse");
        end
        @(negedge pclk);
        n_checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b oe=%b expected 0 0", busy, miso_oe);
        end
        clk_wait(2 * H);
        n_checks++;
        if (n_abort - a0 != 1 || n_wen - w0 != 0 || n_tc - t0 != 0) begin
            n_fail++;
            $display("FAIL abort_counts: got abort=%0d wen=%0d tc=%0d expected 1 0 0", n_abort - a0, n_wen - w0, n_tc - t0);
        end
    endtask

    // use_reset=1 pulses preset, otherwise drops spie, four samples into a word
    task automatic test_kill_midword(input logic use_reset, input logic [31:0] tx_after);
        int w0 = n_wen;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        push_tx(32'h5C, 8, 4);
        ss_assert();
        spi_word(32'h77, 8, 4, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midword_busy: got busy=%b expected 1", busy);
        end
        if (use_reset) preset = 1'b1; else spie = 1'b0;
        clk_wait(1);
        n_checks++;
        if ({miso_out, miso_oe, tfifo_ren, rfifo_wen, transfer_complete, busy, tx_underrun,
             rx_overrun, ss_abort} !== 9'b0 || rfifo_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL kill_outputs (reset=%b): got flags %b data %h expected all 0", use_reset,
                     {miso_out, miso_oe, tfifo_ren, rfifo_wen, transfer_complete, busy,
                      tx_underrun, rx_overrun, ss_abort}, rfifo_wdata);
        end
        preset = 1'b0; spie = 1'b1;
        clk_wait(2);
        ss_release();
        push_tx(tx_after, 8, 8);
        exp_rx.push_back(32'h00000096);
        ss_assert();
        spi_word(32'h96, 8, 8, 1'b1);
        n_checks++;
        if (n_wen - w0 != 1) begin
            n_fail++;
            $display("FAIL kill_recover (reset=%b): got wen=%0d expected 1", use_reset, n_wen - w0);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_kill_midword(1'b1, 32'h69);
        test_kill_midword(1'b0, 32'hC3);
        clk_wait(10);
        n_checks++;
        if (exp_rx.size() != 0 || exp_miso.size() != 0 || txq.size() != 0) begin
            n_fail++;
            $display("FAIL leftovers: got rx=%0d miso=%0d tx=%0d pending expected 0 0 0",
                     exp_rx.size(), exp_miso.size(), txq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
